// File: rtl/time_src_select.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : time_src_select                                                |
// | Brief   : N-channel time-word selector for the display path. Registered  |
// |           output, timed blanking on source change, and display freeze.   |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module time_src_select #(
  parameter int N_CH     = 4,
  parameter int TIME_W   = 24,
  parameter int HOLD_CYC = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_CH*TIME_W-1:0]     i_time,
  input  logic                       btn_next,
  input  logic                       sel_load,
  input  logic [$clog2(N_CH)-1:0]    sel_idx,
  input  logic                       freeze,
  output logic [TIME_W-1:0]          o_time,
  output logic [$clog2(N_CH)-1:0]    o_sel,
  output logic                       o_blank,
  output logic                       o_frozen,
  output logic                       o_err
);

  localparam int SEL_W = $clog2(N_CH);
  // A zero-length blanking window still needs a 1-bit counter to keep widths legal.
  localparam int CNT_W = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;
  localparam logic [SEL_W-1:0] LAST_SEL  = SEL_W'(N_CH - 1);
  localparam logic [SEL_W:0]   N_CH_EXT  = (SEL_W + 1)'(N_CH);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
  localparam bit               USE_BLANK = (HOLD_CYC > 0);

  typedef enum logic [0:0] {
    SHOW   = 1'b0,
    SWITCH = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [SEL_W-1:0]   sel_nxt;
  logic [TIME_W-1:0]  time_nxt;
  logic               blank_nxt;
  logic               frozen_nxt;
  logic               err_nxt;

  logic [TIME_W-1:0]  cur_time;
  logic [SEL_W-1:0]   step_idx;
  logic [SEL_W-1:0]   target;
  logic               req;
  logic               idx_bad;
  logic               reject;
  logic               accept;

  // Pick the time word of the currently selected channel.
  always_comb begin
    cur_time = '0;
    for (int j = 0; j < N_CH; j++) begin
      if (o_sel == SEL_W'(j)) begin
        cur_time = i_time[j*TIME_W +: TIME_W];
      end
    end
  end

  // Request decode: sel_load wins over btn_next; stepping wraps at the last channel.
  always_comb begin
    req      = sel_load | btn_next;
    step_idx = (o_sel == LAST_SEL) ? '0 : o_sel + SEL_W'(1);
    target   = sel_load ? sel_idx : step_idx;
    idx_bad  = sel_load && ({1'b0, sel_idx} >= N_CH_EXT);
    reject   = req && ((state == SWITCH) || freeze || idx_bad);
    accept   = req && !reject;
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    sel_nxt    = o_sel;
    time_nxt   = o_time;
    blank_nxt  = o_blank;
    frozen_nxt = 1'b0;
    err_nxt    = reject;

    case (state)
      SHOW: begin
        if (accept) begin
          sel_nxt = target;
          if (USE_BLANK) begin
            // Old value stays on the display while the window runs.
            state_nxt = SWITCH;
            cnt_nxt   = HOLD_LOAD;
            blank_nxt = 1'b1;
          end else begin
            // New index takes effect on the edge after this one.
            time_nxt = cur_time;
          end
        end else if (freeze) begin
          frozen_nxt = 1'b1;
        end else begin
          time_nxt = cur_time;
        end
      end
      SWITCH: begin
        // Freeze has no effect here; the window always runs to completion.
        if (cnt == '0) begin
          state_nxt = SHOW;
          blank_nxt = 1'b0;
          time_nxt  = cur_time;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = SHOW;
        blank_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= SHOW;
      cnt      <= '0;
      o_sel    <= '0;
      o_time   <= '0;
      o_blank  <= 1'b0;
      o_frozen <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      o_sel    <= sel_nxt;
      o_time   <= time_nxt;
      o_blank  <= blank_nxt;
      o_frozen <= frozen_nxt;
      o_err    <= err_nxt;
    end
  end

endmodule
`default_nettype wire
